// File: rtl/switch_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce_pkg
// Description : Shared constants and FSM state encoding for the switch
//               debouncer (board clock, default 10 ms qualification window,
//               matching counter width).
// Revision    : 1.0  initial release
// ============================================================================
package switch_debounce_pkg;

    // Board clock frequency
    localparam int CLK_HZ          = 50000000;
    // 10 ms at CLK_HZ
    localparam int DEB_STABLE_10MS = 500000;
    // Smallest width with 2^W >= DEB_STABLE_10MS
    localparam int DEB_CNT_W       = 19;

    // Per-channel qualification FSM
    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } deb_state_t;

endpackage : switch_debounce_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One debounced input bit: two-flop synchroniser, stable-count
//               qualification FSM and optional registered edge pulses.
//               Edge pulses are compiled in when SWITCH_DEBOUNCE_EDGE_EN is
//               defined; otherwise o_rise/o_fall are tied low.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               i_raw        - asynchronous pin
//               o_level      - debounced level
//               o_rise/o_fall- one-cycle pulse with each level change
// Revision    : 1.0  initial release
// ============================================================================
module debounce_channel
    import switch_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_STABLE_10MS,
    parameter int CNT_W         = DEB_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    deb_state_t       r_state;

    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_STABLE;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_level <= w_level_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. r_cnt holds the number of consecutive cycles the
    // synchronised input has already disagreed with the level.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        case (r_state)
            ST_STABLE: begin
                w_cnt_nxt = '0;
                if (r_s2 != r_level) begin
                    if (c_cnt_last == '0) begin
                        // Single-cycle window: accept immediately
                        w_level_nxt = r_s2;
                    end else begin
                        w_state_nxt = ST_COUNT;
                        w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_COUNT: begin
                if (r_s2 == r_level) begin
                    // Bounce back: restart qualification
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_level_nxt = r_s2;
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_level = r_level;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Pulses are registered alongside r_level so they coincide with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_level_nxt & ~r_level;
            r_fall <= ~w_level_nxt & r_level;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule : debounce_channel
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : WIDTH independent debounced switch/button channels feeding
//               the gate stage (level[0] -> a, level[1] -> b).
//               Define SWITCH_DEBOUNCE_EDGE_EN to enable rise/fall pulses;
//               without it they are tied low and the ports remain.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               raw       - asynchronous pins [WIDTH]
//               level     - debounced levels  [WIDTH]
//               rise/fall - one-cycle edge pulses [WIDTH]
// Revision    : 1.0  initial release
// ============================================================================
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = DEB_STABLE_10MS,
    parameter int CNT_W         = DEB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (raw[gi]),
            .o_level (level[gi]),
            .o_rise  (rise[gi]),
            .o_fall  (fall[gi])
        );
    end

endmodule : switch_debounce
`default_nettype wire
